alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Reservation station that feeds the combinational ALU; it is the issue side of the ALU interface.
- Accepts decoded ALU/branch/jump instructions from the dispatcher.
- Holds them until both source operands are known, capturing results broadcast on the ALU and LSB CDBs.
- Each cycle, sends at most one ready instruction to the ALU through registered outputs.

Parameters:
- RS_SIZE, 16, number of station entries (power of two).
- RS_IDX_W, 4, log2(RS_SIZE).
- ROB_ID_W, 4, width of ROB tags.

Ports:
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable; low freezes all state.
- rollback  in  1  misprediction flush.
- issue_valid  in  1  dispatcher presents an instruction.
- issue_openum  in  `OPENUM_TYPE  operation code.
- issue_v1, issue_v2  in  32 each  operand values, meaningful when the matching has_q bit is 0.
- issue_has_q1, issue_has_q2  in  1 each  operand still pending.
- issue_q1, issue_q2  in  ROB_ID_W each  producing ROB tag.
- issue_imm  in  32  immediate.
- issue_pc  in  32  instruction pc.
- issue_rob_id  in  ROB_ID_W  destination tag.
- alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value  in  1/ROB_ID_W/32  ALU broadcast.
- lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value  in  1/ROB_ID_W/32  LSB broadcast.
- rs_full  out  1  combinational; every entry busy.
- alu_openum  out  `OPENUM_TYPE  registered; `OPENUM_NOP when idle.
- alu_v1, alu_v2, alu_imm, alu_pc  out  32 each  registered operands.
- alu_rob_id  out  ROB_ID_W  registered tag.

Behaviour:
- Reset (rst_in low, asynchronous):
  - all busy bits cleared;
  - alu_openum=`OPENUM_NOP;
  - alu_v1/v2/imm/pc=0, alu_rob_id=0;
  - rs_full=0.
- Entry fields: busy, openum, v1, v2, has_q1, has_q2, q1, q2, imm, pc, rob_id.
- Ready: busy && !has_q1 && !has_q2.
- Priority at each edge, when rst_in is high:
  1. rdy_in low: hold all state, outputs unchanged.
  2. rollback: clear every busy bit; outputs become NOP with zero data. Any issue that cycle is dropped.
  3. Otherwise, do issue, wakeup and dispatch together.
- Issue:
  - If issue_valid && !rs_full, write into the lowest-index free entry.
  - When issue_valid is high while rs_full is high, the issue is ignored. Flag it in simulation; it is a dispatcher bug.
- Issue bypass:
  - If an incoming has_qN is set and either CDB is valid with a matching rob_id that same cycle, store the CDB value and clear has_qN.
  - When both CDBs match, take the ALU value.
- Wakeup: for every busy entry and each operand with has_qN and qN equal to a valid CDB rob_id, latch the value and clear has_qN. The ALU CDB takes precedence over the LSB CDB.
- Dispatch:
  - Select the lowest-index ready entry as of the start of the cycle. Entries woken or issued this edge are not eligible.
  - Copy its fields to the alu_* outputs and clear its busy bit.
  - If no entry is ready, alu_openum=`OPENUM_NOP. Other outputs are don't-care, but drive 0.
- Latency:
  - Operands ready at issue: issue at edge t, entry busy after t, dispatched at edge t+1, ALU result combinational in the cycle after t+1.
  - Pending operand: woken at edge e, dispatched no earlier than e+1.
- Simultaneous issue into a freed slot: the entry dispatched at this edge is not reusable until the next cycle. Free selection uses start-of-cycle busy bits.
- rs_full = AND of busy bits, combinational from state only.
- Widths: no arithmetic inside the block. All values pass through unmodified.
- Reset mid-operation: asynchronous clear overrides rollback and issue. Outputs become NOP immediately, without waiting for a clock edge.

Decomposition:
- Shared constant.v: `OPENUM_TYPE, the `OPENUM_* codes including `OPENUM_NOP, `DATA_TYPE, `ADDR_TYPE, `ROB_ID_TYPE, `RS_SIZE, `TRUE/`FALSE, `ZERO_WORD.
- Sub-module rs_priority_enc: RS_SIZE-bit vector in, lowest-set index plus a found flag out.
- Instantiate rs_priority_enc twice: once on ~busy for free selection, once on the ready vector for dispatch.

Test Plan:
- Reset, then issue ADD with v1=5, v2=7, no deps, rob 3 -> next cycle alu_openum=ADD, alu_v1=5, alu_v2=7, alu_rob_id=3. The station is empty afterward.
- Issue ADDI with has_q1, q1=2, imm=1; two cycles later ALU CDB rob 2 value 0x10 -> alu_openum stays NOP until the edge after wakeup, then ADDI with alu_v1=0x10, alu_imm=1.
- Issue with has_q2, q2=5 while LSB CDB rob 5 value 0xAB fires in the same cycle -> entry stores v2=0xAB. Dispatched at the next edge.
- Both CDBs broadcast tag 4 (ALU value 1, LSB value 2) to a waiting entry -> v1=1.
- Fill 16 entries all waiting on tag 9 -> rs_full=1 and a 17th issue is ignored. CDB tag 9 -> entries dispatch in index order 0..15, one per cycle.
- Cases for rollback and rdy_in:
  - Three busy entries, rollback -> next cycle alu_openum=NOP, rs_full=0, no later dispatches.
  - rdy_in low for 3 cycles mid-stream -> outputs and contents hold.
  - rst_in pulsed low between edges -> outputs are NOP immediately.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared types, widths and operation codes for the ALU reservation station.
package alu_rs_pkg;

    localparam int unsigned RS_SIZE  = 16;
    localparam int unsigned RS_IDX_W = 4;
    localparam int unsigned ROB_ID_W = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OPENUM_W = 6;

    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [OPENUM_W-1:0] openum_t;

    localparam openum_t OPENUM_NOP  = 6'd0;
    localparam openum_t OPENUM_ADD  = 6'd1;
    localparam openum_t OPENUM_SUB  = 6'd2;
    localparam openum_t OPENUM_ADDI = 6'd3;
    localparam openum_t OPENUM_AND  = 6'd4;
    localparam openum_t OPENUM_OR   = 6'd5;
    localparam openum_t OPENUM_XOR  = 6'd6;
    localparam openum_t OPENUM_SLT  = 6'd7;
    localparam openum_t OPENUM_BEQ  = 6'd8;
    localparam openum_t OPENUM_JAL  = 6'd9;

    typedef struct packed {
        logic    valid;
        rob_id_t rob_id;
        data_t   value;
    } cdb_t;

    typedef struct packed {
        logic    has_q;
        rob_id_t q;
        data_t   v;
    } opnd_t;

    typedef struct packed {
        logic    busy;
        openum_t openum;
        opnd_t   op1;
        opnd_t   op2;
        data_t   imm;
        data_t   pc;
        rob_id_t rob_id;
    } rs_entry_t;

    typedef struct packed {
        openum_t openum;
        data_t   v1;
        data_t   v2;
        data_t   imm;
        data_t   pc;
        rob_id_t rob_id;
    } alu_issue_t;

    // Resolve a pending operand from the CDBs; the ALU broadcast wins a tie.
    function automatic opnd_t capture_operand(opnd_t cur, cdb_t alu_cdb, cdb_t lsb_cdb);
        opnd_t res;
        res = cur;
        if (cur.has_q) begin
            if (alu_cdb.valid && (alu_cdb.rob_id == cur.q)) begin
                res.v     = alu_cdb.value;
                res.has_q = 1'b0;
            end else if (lsb_cdb.valid && (lsb_cdb.rob_id == cur.q)) begin
                res.v     = lsb_cdb.value;
                res.has_q = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_priority_enc.sv
// Lowest-set-bit encoder used for free-slot and ready-entry selection.
module rs_priority_enc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched instructions until operands
// resolve via the CDBs, then issues at most one per cycle to the ALU.
module alu_rs
    import alu_rs_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                rollback,
    input  logic                issue_valid,
    input  logic [OPENUM_W-1:0] issue_openum,
    input  logic [DATA_W-1:0]   issue_v1,
    input  logic [DATA_W-1:0]   issue_v2,
    input  logic                issue_has_q1,
    input  logic                issue_has_q2,
    input  logic [ROB_ID_W-1:0] issue_q1,
    input  logic [ROB_ID_W-1:0] issue_q2,
    input  logic [DATA_W-1:0]   issue_imm,
    input  logic [DATA_W-1:0]   issue_pc,
    input  logic [ROB_ID_W-1:0] issue_rob_id,
    input  logic                alu_cdb_valid,
    input  logic [ROB_ID_W-1:0] alu_cdb_rob_id,
    input  logic [DATA_W-1:0]   alu_cdb_value,
    input  logic                lsb_cdb_valid,
    input  logic [ROB_ID_W-1:0] lsb_cdb_rob_id,
    input  logic [DATA_W-1:0]   lsb_cdb_value,
    output logic                rs_full,
    output logic [OPENUM_W-1:0] alu_openum,
    output logic [DATA_W-1:0]   alu_v1,
    output logic [DATA_W-1:0]   alu_v2,
    output logic [DATA_W-1:0]   alu_imm,
    output logic [DATA_W-1:0]   alu_pc,
    output logic [ROB_ID_W-1:0] alu_rob_id
);

    rs_entry_t  entry_q [RS_SIZE];
    rs_entry_t  entry_d [RS_SIZE];
    alu_issue_t out_q, out_d;

    logic [RS_SIZE-1:0]  busy_c, ready_c;
    logic [RS_IDX_W-1:0] free_idx_c, disp_idx_c;
    logic                free_found_c, disp_found_c;
    cdb_t                alu_cdb_c, lsb_cdb_c;
    rs_entry_t           new_entry_c;

    assign alu_cdb_c = '{valid: alu_cdb_valid, rob_id: alu_cdb_rob_id, value: alu_cdb_value};
    assign lsb_cdb_c = '{valid: lsb_cdb_valid, rob_id: lsb_cdb_rob_id, value: lsb_cdb_value};

    // Start-of-cycle status; entries woken or written this edge are not eligible.
    always_comb begin
        busy_c  = '0;
        ready_c = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            busy_c[i]  = entry_q[i].busy;
            ready_c[i] = entry_q[i].busy && !entry_q[i].op1.has_q && !entry_q[i].op2.has_q;
        end
    end

    assign rs_full = &busy_c;

    rs_priority_enc #(.WIDTH(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_enc (
        .vec_i   (~busy_c),
        .idx_o   (free_idx_c),
        .found_o (free_found_c)
    );

    rs_priority_enc #(.WIDTH(RS_SIZE), .IDX_W(RS_IDX_W)) u_disp_enc (
        .vec_i   (ready_c),
        .idx_o   (disp_idx_c),
        .found_o (disp_found_c)
    );

    // Incoming instruction with same-cycle CDB bypass applied.
    always_comb begin
        new_entry_c        = '0;
        new_entry_c.busy   = 1'b1;
        new_entry_c.openum = issue_openum;
        new_entry_c.op1    = capture_operand('{has_q: issue_has_q1, q: issue_q1, v: issue_v1},
                                             alu_cdb_c, lsb_cdb_c);
        new_entry_c.op2    = capture_operand('{has_q: issue_has_q2, q: issue_q2, v: issue_v2},
                                             alu_cdb_c, lsb_cdb_c);
        new_entry_c.imm    = issue_imm;
        new_entry_c.pc     = issue_pc;
        new_entry_c.rob_id = issue_rob_id;
    end

    // Next state: freeze, flush, or combined issue/wakeup/dispatch.
    always_comb begin
        entry_d = entry_q;
        out_d   = out_q;
        if (rdy_in) begin
            out_d        = '0;
            out_d.openum = OPENUM_NOP;
            if (rollback) begin
                for (int i = 0; i < int'(RS_SIZE); i++) begin
                    entry_d[i].busy = 1'b0;
                end
            end else begin
                for (int i = 0; i < int'(RS_SIZE); i++) begin
                    if (entry_q[i].busy) begin
                        entry_d[i].op1 = capture_operand(entry_q[i].op1, alu_cdb_c, lsb_cdb_c);
                        entry_d[i].op2 = capture_operand(entry_q[i].op2, alu_cdb_c, lsb_cdb_c);
                    end
                end
                if (disp_found_c) begin
                    out_d.openum             = entry_q[disp_idx_c].openum;
                    out_d.v1                 = entry_q[disp_idx_c].op1.v;
                    out_d.v2                 = entry_q[disp_idx_c].op2.v;
                    out_d.imm                = entry_q[disp_idx_c].imm;
                    out_d.pc                 = entry_q[disp_idx_c].pc;
                    out_d.rob_id             = entry_q[disp_idx_c].rob_id;
                    entry_d[disp_idx_c].busy = 1'b0;
                end
                if (issue_valid && free_found_c) begin
                    entry_d[free_idx_c] = new_entry_c;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entry_q[i] <= '0;
            end
            out_q        <= '0;
            out_q.openum <= OPENUM_NOP;
        end else begin
            entry_q <= entry_d;
            out_q   <= out_d;
        end
    end

    assign alu_openum = out_q.openum;
    assign alu_v1     = out_q.v1;
    assign alu_v2     = out_q.v2;
    assign alu_imm    = out_q.imm;
    assign alu_pc     = out_q.pc;
    assign alu_rob_id = out_q.rob_id;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: issue, bypass, wakeup, full, rollback, freeze, reset.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic          clk_in, rst_in, rdy_in, rollback;
    logic          issue_valid;
    openum_t       issue_openum;
    data_t         issue_v1, issue_v2, issue_imm, issue_pc;
    logic          issue_has_q1, issue_has_q2;
    rob_id_t       issue_q1, issue_q2, issue_rob_id;
    logic          alu_cdb_valid, lsb_cdb_valid;
    rob_id_t       alu_cdb_rob_id, lsb_cdb_rob_id;
    data_t         alu_cdb_value, lsb_cdb_value;
    logic          rs_full;
    openum_t       alu_openum;
    data_t         alu_v1, alu_v2, alu_imm, alu_pc;
    rob_id_t       alu_rob_id;

    int vec_cnt = 0;
    int err_cnt = 0;

    alu_rs dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rollback(rollback),
        .issue_valid(issue_valid), .issue_openum(issue_openum),
        .issue_v1(issue_v1), .issue_v2(issue_v2),
        .issue_has_q1(issue_has_q1), .issue_has_q2(issue_has_q2),
        .issue_q1(issue_q1), .issue_q2(issue_q2),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_id(issue_rob_id),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_value(alu_cdb_value),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_value(lsb_cdb_value),
        .rs_full(rs_full), .alu_openum(alu_openum),
        .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_rob_id(alu_rob_id)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        issue_valid   = 1'b0;
        issue_openum  = OPENUM_NOP;
        issue_v1      = '0;
        issue_v2      = '0;
        issue_has_q1  = 1'b0;
        issue_has_q2  = 1'b0;
        issue_q1      = '0;
        issue_q2      = '0;
        issue_imm     = '0;
        issue_pc      = '0;
        issue_rob_id  = '0;
        alu_cdb_valid = 1'b0;
        alu_cdb_rob_id = '0;
        alu_cdb_value = '0;
        lsb_cdb_valid = 1'b0;
        lsb_cdb_rob_id = '0;
        lsb_cdb_value = '0;
        rollback      = 1'b0;
    endtask

    task automatic drive_issue(input openum_t op, input data_t v1, input logic hq1, input rob_id_t q1,
                               input data_t v2, input logic hq2, input rob_id_t q2,
                               input data_t imm, input data_t pc, input rob_id_t rob);
        issue_valid  = 1'b1;
        issue_openum = op;
        issue_v1     = v1;
        issue_has_q1 = hq1;
        issue_q1     = q1;
        issue_v2     = v2;
        issue_has_q2 = hq2;
        issue_q2     = q2;
        issue_imm    = imm;
        issue_pc     = pc;
        issue_rob_id = rob;
    endtask

    task automatic check_out(input string tag, input openum_t op, input data_t v1, input data_t v2,
                             input data_t imm, input rob_id_t rob);
        check({tag, ".op"},  32'(alu_openum), 32'(op));
        check({tag, ".v1"},  alu_v1, v1);
        check({tag, ".v2"},  alu_v2, v2);
        check({tag, ".imm"}, alu_imm, imm);
        check({tag, ".rob"}, 32'(alu_rob_id), 32'(rob));
    endtask

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        idle();
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_op", 32'(alu_openum), 32'(OPENUM_NOP));
        check("rst_v1", alu_v1, 32'h0);
        check("rst_pc", alu_pc, 32'h0);
        check("rst_rob", 32'(alu_rob_id), 32'h0);
        check("rst_full", 32'(rs_full), 32'h0);
        rst_in = 1'b1;
        tick();

        // Ready at issue: dispatched one edge after the write.
        drive_issue(OPENUM_ADD, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 32'd0, 32'h40, 4'd3);
        tick();
        idle();
        check("add_wait", 32'(alu_openum), 32'(OPENUM_NOP));
        tick();
        check_out("add", OPENUM_ADD, 32'd5, 32'd7, 32'd0, 4'd3);
        check("add_pc", alu_pc, 32'h40);
        tick();
        check("add_empty", 32'(alu_openum), 32'(OPENUM_NOP));

        // Pending operand woken by ALU CDB; dispatch one edge after wakeup.
        drive_issue(OPENUM_ADDI, 32'd0, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd1, 32'h100, 4'd6);
        tick();
        idle();
        tick();
        check("addi_pend", 32'(alu_openum), 32'(OPENUM_NOP));
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd2; alu_cdb_value = 32'h10;
        tick();
        idle();
        check("addi_wake", 32'(alu_openum), 32'(OPENUM_NOP));
        tick();
        check_out("addi", OPENUM_ADDI, 32'h10, 32'd0, 32'd1, 4'd6);
        check("addi_pc", alu_pc, 32'h100);

        // Issue bypass from the LSB CDB.
        drive_issue(OPENUM_SUB, 32'd3, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'd0, 32'h0, 4'd7);
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd5; lsb_cdb_value = 32'hAB;
        tick();
        idle();
        check("byp_wait", 32'(alu_openum), 32'(OPENUM_NOP));
        tick();
        check_out("byp", OPENUM_SUB, 32'd3, 32'hAB, 32'd0, 4'd7);

        // Both CDBs carry the same tag: ALU value wins.
        drive_issue(OPENUM_AND, 32'd0, 1'b1, 4'd4, 32'h55, 1'b0, 4'd0, 32'd0, 32'h0, 4'd8);
        tick();
        idle();
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd4; alu_cdb_value = 32'd1;
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd4; lsb_cdb_value = 32'd2;
        tick();
        idle();
        tick();
        check_out("tie", OPENUM_AND, 32'd1, 32'h55, 32'd0, 4'd8);

        // Fill all entries waiting on tag 9; extra issue is dropped.
        for (int i = 0; i < 16; i++) begin
            drive_issue(OPENUM_ADD, 32'd0, 1'b1, 4'd9, 32'(i), 1'b0, 4'd0, 32'(i), 32'(i * 4), 4'(i));
            tick();
        end
        idle();
        check("full", 32'(rs_full), 32'h1);
        drive_issue(OPENUM_XOR, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'h99, 32'h0, 4'd15);
        tick();
        idle();
        check("full_hold", 32'(rs_full), 32'h1);
        check("full_nop", 32'(alu_openum), 32'(OPENUM_NOP));
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd9; alu_cdb_value = 32'h900;
        tick();
        idle();
        check("full_wake", 32'(alu_openum), 32'(OPENUM_NOP));
        for (int i = 0; i < 16; i++) begin
            tick();
            check_out($sformatf("drain%0d", i), OPENUM_ADD, 32'h900, 32'(i), 32'(i), 4'(i));
            if (i == 0) check("drain_notfull", 32'(rs_full), 32'h0);
        end
        tick();
        check("drain_done", 32'(alu_openum), 32'(OPENUM_NOP));

        // Rollback flushes pending entries and drops a same-cycle issue.
        for (int i = 0; i < 3; i++) begin
            drive_issue(OPENUM_OR, 32'd0, 1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'd0, 32'h0, 4'(i));
            tick();
        end
        idle();
        drive_issue(OPENUM_SUB, 32'd9, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 32'd0, 32'h0, 4'd12);
        rollback = 1'b1;
        tick();
        idle();
        check("rb_nop", 32'(alu_openum), 32'(OPENUM_NOP));
        check("rb_full", 32'(rs_full), 32'h0);
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd1; alu_cdb_value = 32'h77;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rb_quiet%0d", i), 32'(alu_openum), 32'(OPENUM_NOP));
        end

        // Freeze: outputs and contents hold while rdy_in is low.
        drive_issue(OPENUM_ADD, 32'hA, 1'b0, 4'd0, 32'hB, 1'b0, 4'd0, 32'd0, 32'h0, 4'd10);
        tick();
        drive_issue(OPENUM_OR, 32'hC, 1'b0, 4'd0, 32'hD, 1'b0, 4'd0, 32'd2, 32'h0, 4'd11);
        tick();
        idle();
        check_out("pre_frz", OPENUM_ADD, 32'hA, 32'hB, 32'd0, 4'd10);
        rdy_in = 1'b0;
        drive_issue(OPENUM_SLT, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 32'h0, 4'd12);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("frz%0d.op", i), 32'(alu_openum), 32'(OPENUM_ADD));
            check($sformatf("frz%0d.rob", i), 32'(alu_rob_id), 32'd10);
        end
        idle();
        rdy_in = 1'b1;
        tick();
        check_out("post_frz", OPENUM_OR, 32'hC, 32'hD, 32'd2, 4'd11);
        tick();
        check("post_frz_nop", 32'(alu_openum), 32'(OPENUM_NOP));

        // Asynchronous reset between edges clears outputs immediately.
        drive_issue(OPENUM_JAL, 32'h5, 1'b0, 4'd0, 32'h6, 1'b0, 4'd0, 32'h8, 32'h200, 4'd13);
        tick();
        drive_issue(OPENUM_BEQ, 32'h1, 1'b1, 4'd3, 32'h1, 1'b0, 4'd0, 32'h0, 32'h0, 4'd14);
        tick();
        idle();
        check("pre_rst", 32'(alu_openum), 32'(OPENUM_JAL));
        #1 rst_in = 1'b0;
        #1;
        check("async_op", 32'(alu_openum), 32'(OPENUM_NOP));
        check("async_rob", 32'(alu_rob_id), 32'h0);
        check("async_pc", alu_pc, 32'h0);
        #1 rst_in = 1'b1;
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd3; alu_cdb_value = 32'h3;
        tick();
        idle();
        tick();
        check("post_rst_nop", 32'(alu_openum), 32'(OPENUM_NOP));
        check("post_rst_full", 32'(rs_full), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
